// File: rtl/fifo_drain_pkg.sv
// Shared types and helpers for the FIFO drain controller.
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOADED,
        GAP,
        FLUSH
    } drain_state_t;

    // Width of a counter that can hold values 0..max_burst.
    function automatic int burst_cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_drain_ctrl.sv
// FIFO drain controller: pops words from a show-ahead FIFO and offers them
// downstream on a valid/ready link at one word per cycle.
// - Bursts are capped at MAX_BURST words, followed by a forced gap cycle.
// - A flush discards the held word and empties the FIFO.
// - Optional accepted-word counter on cnt_o, built only when the macro
//   FIFO_DRAIN_CNT_EN is defined; otherwise cnt_o is tied to zero.
module fifo_drain_ctrl
    import fifo_drain_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic             fifo_pndng_i,
    input  logic [WIDTH-1:0] fifo_dato_i,
    output logic             fifo_pop_o,
    output logic [WIDTH-1:0] dato_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int BW = burst_cnt_w(MAX_BURST);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    drain_state_t    state;
    drain_state_t    state_next;
    logic [WIDTH-1:0] dato_next;
    logic             valid_next;
    logic [BW-1:0]    burst;
    logic [BW-1:0]    burst_next;
    logic             pop;
    logic             take;
    logic             fire;

    assign take = en_i && fifo_pndng_i && !flush_i;
    assign fire = valid_o && ready_i;

    // Next-state, next-output and pop decision; flush overrides every state.
    always_comb begin
        state_next = state;
        dato_next  = dato_o;
        valid_next = valid_o;
        burst_next = burst;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    pop        = 1'b1;
                    state_next = LOADED;
                    dato_next  = fifo_dato_i;
                    valid_next = 1'b1;
                    burst_next = '0;
                end
            end
            LOADED: begin
                if (fire) begin
                    if (take && (burst < BURST_LAST)) begin
                        pop        = 1'b1;
                        dato_next  = fifo_dato_i;
                        burst_next = burst + 1'b1;
                    end else if (burst == BURST_LAST) begin
                        valid_next = 1'b0;
                        state_next = GAP;
                    end else begin
                        valid_next = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            FLUSH: begin
                pop = fifo_pndng_i;
                if (!flush_i && !fifo_pndng_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (flush_i) begin
            state_next = FLUSH;
            valid_next = 1'b0;
        end
    end

    // The FIFO must never see a pop while the controller is held in reset.
    assign fifo_pop_o = pop && rst_n;
    assign busy_o     = (state != IDLE);

    // State register and registered downstream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            dato_o  <= '0;
            valid_o <= 1'b0;
            burst   <= '0;
        end else begin
            state   <= state_next;
            dato_o  <= dato_next;
            valid_o <= valid_next;
            burst   <= burst_next;
        end
    end

`ifdef FIFO_DRAIN_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Count words actually accepted downstream; a word lost to flush is not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (fire && !flush_i) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign cnt_o = cnt;
`else
    assign cnt_o = '0;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed self-checking bench for fifo_drain_ctrl (default parameters).
module tb_fifo_drain_ctrl;

    localparam int WIDTH     = 16;
    localparam int MAX_BURST = 4;
    localparam int CNT_W     = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en_i;
    logic             flush_i;
    logic             ready_i;
    logic             hide;
    logic             fifo_pndng_i;
    logic [WIDTH-1:0] fifo_dato_i;
    logic             fifo_pop_o;
    logic [WIDTH-1:0] dato_o;
    logic             valid_o;
    logic             busy_o;
    logic [CNT_W-1:0] cnt_o;

    // Source FIFO model: words written by the tasks, removed on pop.
    logic [WIDTH-1:0] mem [0:63];
    int               wr_ptr = 0;
    int               rd_ptr = 0;
    int               pop_total = 0;
    int               pop_err = 0;

    int               checks = 0;
    int               failures = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    fifo_drain_ctrl #(
        .WIDTH(WIDTH),
        .MAX_BURST(MAX_BURST),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en_i(en_i),
        .flush_i(flush_i),
        .fifo_pndng_i(fifo_pndng_i),
        .fifo_dato_i(fifo_dato_i),
        .fifo_pop_o(fifo_pop_o),
        .dato_o(dato_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .busy_o(busy_o),
        .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    assign fifo_pndng_i = (wr_ptr != rd_ptr) && !hide;
    assign fifo_dato_i  = mem[rd_ptr % 64];

    // FIFO model pop; a pop with pndng low is a protocol error.
    always @(posedge clk) begin
        if (fifo_pop_o) begin
            if (!fifo_pndng_i) pop_err <= pop_err + 1;
            else rd_ptr <= rd_ptr + 1;
            pop_total <= pop_total + 1;
        end
    end

    task automatic push(input logic [WIDTH-1:0] w);
        mem[wr_ptr % 64] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic accept();
`ifdef FIFO_DRAIN_CNT_EN
        exp_cnt = exp_cnt + 1'b1;
`endif
    endtask

    // Reset values, no pop while held in reset, then drain one word.
    task automatic test_reset();
        rst_n = 1'b0; en_i = 1'b1; flush_i = 1'b0; ready_i = 1'b1; hide = 1'b0;
        push(16'h0055);
        #2;
        checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid got=%0b exp=0", valid_o); end
        checks++; if (dato_o !== 16'h0) begin failures++; $display("[TB] FAIL rst_dato got=%h exp=0000", dato_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%0b exp=0", busy_o); end
        checks++; if (cnt_o !== '0) begin failures++; $display("[TB] FAIL rst_cnt got=%0d exp=0", cnt_o); end
        checks++; if (fifo_pop_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_pop got=%0b exp=0", fifo_pop_o); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (fifo_pop_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_first_pop got=%0b exp=1", fifo_pop_o); end
        @(negedge clk); #1;
        checks++; if (valid_o !== 1'b1 || dato_o !== 16'h0055) begin failures++; $display("[TB] FAIL rst_first_word got=%0b/%h exp=1/0055", valid_o, dato_o); end
        accept();
        @(negedge clk); #1;
        checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_idle got=%0b/%0b exp=0/0", valid_o, busy_o); end
        checks++; if (pop_total !== 1) begin failures++; $display("[TB] FAIL rst_pops got=%0d exp=1", pop_total); end
    endtask

    // Two words with ready high: one-cycle latency, back-to-back delivery.
    task automatic test_basic();
        int p0;
        p0 = pop_total;
        @(negedge clk); push(16'h0006); push(16'h000A); #1;
        checks++; if (fifo_pop_o !== 1'b1) begin failures++; $display("[TB] FAIL basic_pop0 got=%0b exp=1", fifo_pop_o); end
        @(negedge clk); #1;
        checks++; if (valid_o !== 1'b1 || dato_o !== 16'h0006) begin failures++; $display("[TB] FAIL basic_w0 got=%0b/%h exp=1/0006", valid_o, dato_o); end
        checks++; if (fifo_pop_o !== 1'b1) begin failures++; $display("[TB] FAIL basic_pop1 got=%0b exp=1", fifo_pop_o); end
        accept();
        @(negedge clk); #1;
        checks++; if (valid_o !== 1'b1 || dato_o !== 16'h000A) begin failures++; $display("[TB] FAIL basic_w1 got=%0b/%h exp=1/000a", valid_o, dato_o); end
        checks++; if (fifo_pop_o !== 1'b0) begin failures++; $display("[TB] FAIL basic_pop2 got=%0b exp=0", fifo_pop_o); end
        accept();
        @(negedge clk); #1;
        checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("[TB] FAIL basic_idle got=%0b/%0b exp=0/0", valid_o, busy_o); end
        checks++; if (pop_total - p0 !== 2) begin failures++; $display("[TB] FAIL basic_pops got=%0d exp=2", pop_total - p0); end
        checks++; if (cnt_o !== exp_cnt) begin failures++; $display("[TB] FAIL basic_cnt got=%0d exp=%0d", cnt_o, exp_cnt); end
    endtask

    // Downstream stall: held word stays stable and no further pops occur.
    task automatic test_backpressure();
        int p0;
        p0 = pop_total;
        @(negedge clk); ready_i = 1'b0; push(16'h0006); push(16'h000A); push(16'h000B); #1;
        checks++; if (fifo_pop_o !== 1'b1) begin failures++; $display("[TB] FAIL bp_pop0 got=%0b exp=1", fifo_pop_o); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++; if (valid_o !== 1'b1 || dato_o !== 16'h0006 || fifo_pop_o !== 1'b0) begin
                failures++; $display("[TB] FAIL bp_hold%0d got=%0b/%h/%0b exp=1/0006/0", i, valid_o, dato_o, fifo_pop_o);
            end
        end
        checks++; if (pop_total - p0 !== 1) begin failures++; $display("[TB] FAIL bp_single_pop got=%0d exp=1", pop_total - p0); end
        @(negedge clk); ready_i = 1'b1; #1;
        checks++; if (dato_o !== 16'h0006 || fifo_pop_o !== 1'b1) begin failures++; $display("[TB] FAIL bp_release got=%h/%0b exp=0006/1", dato_o, fifo_pop_o); end
        accept();
        @(negedge clk); #1;
        checks++; if (valid_o !== 1'b1 || dato_o !== 16'h000A || fifo_pop_o !== 1'b1) begin failures++; $display("[TB] FAIL bp_w1 got=%0b/%h/%0b exp=1/000a/1", valid_o, dato_o, fifo_pop_o); end
        accept();
        @(negedge clk); #1;
        checks++; if (valid_o !== 1'b1 || dato_o !== 16'h000B || fifo_pop_o !== 1'b0) begin failures++; $display("[TB] FAIL bp_w2 got=%0b/%h/%0b exp=1/000b/0", valid_o, dato_o, fifo_pop_o); end
        accept();
        @(negedge clk); #1;
        checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("[TB] FAIL bp_idle got=%0b/%0b exp=0/0", valid_o, busy_o); end
    endtask

    // Ten words with MAX_BURST=4: groups of four, GAP then IDLE between groups.
    task automatic test_burst();
        logic [14:0] exp_pop;
        logic [14:0] exp_valid;
        int          k;
        int          p0;
        exp_pop   = 15'h33CF;
        exp_valid = 15'h679E;
        k  = 0;
        p0 = pop_total;
        @(negedge clk);
        for (int w = 0; w < 10; w++) push(16'h0100 + 16'(w));
        for (int i = 0; i < 15; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            checks++; if (fifo_pop_o !== exp_pop[i]) begin failures++; $display("[TB] FAIL burst_pop_c%0d got=%0b exp=%0b", i, fifo_pop_o, exp_pop[i]); end
            checks++; if (valid_o !== exp_valid[i]) begin failures++; $display("[TB] FAIL burst_valid_c%0d got=%0b exp=%0b", i, valid_o, exp_valid[i]); end
            if (exp_valid[i]) begin
                checks++; if (dato_o !== 16'h0100 + 16'(k)) begin failures++; $display("[TB] FAIL burst_dato_c%0d got=%h exp=%h", i, dato_o, 16'h0100 + 16'(k)); end
                k++;
                accept();
            end
        end
        @(negedge clk); #1;
        checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("[TB] FAIL burst_idle got=%0b/%0b exp=0/0", valid_o, busy_o); end
        checks++; if (pop_total - p0 !== 10) begin failures++; $display("[TB] FAIL burst_pops got=%0d exp=10", pop_total - p0); end
    endtask

    // Flush while a word is held: word lost, remaining four popped, counter unchanged.
    task automatic test_flush();
        int p0;
        p0 = pop_total;
        @(negedge clk); ready_i = 1'b0;
        for (int w = 0; w < 5; w++) push(16'h0200 + 16'(w));
        #1;
        checks++; if (fifo_pop_o !== 1'b1) begin failures++; $display("[TB] FAIL flush_pop0 got=%0b exp=1", fifo_pop_o); end
        @(negedge clk); flush_i = 1'b1; ready_i = 1'b1; #1;
        checks++; if (valid_o !== 1'b1 || dato_o !== 16'h0200 || fifo_pop_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_held got=%0b/%h/%0b exp=1/0200/0", valid_o, dato_o, fifo_pop_o); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); flush_i = 1'b0; #1;
            checks++; if (valid_o !== 1'b0 || busy_o !== 1'b1 || fifo_pop_o !== 1'b1) begin
                failures++; $display("[TB] FAIL flush_drain%0d got=%0b/%0b/%0b exp=0/1/1", i, valid_o, busy_o, fifo_pop_o);
            end
        end
        @(negedge clk); #1;
        checks++; if (fifo_pop_o !== 1'b0 || busy_o !== 1'b1) begin failures++; $display("[TB] FAIL flush_empty got=%0b/%0b exp=0/1", fifo_pop_o, busy_o); end
        @(negedge clk); #1;
        checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_idle got=%0b/%0b exp=0/0", busy_o, valid_o); end
        checks++; if (pop_total - p0 !== 5) begin failures++; $display("[TB] FAIL flush_pops got=%0d exp=5", pop_total - p0); end
        checks++; if (cnt_o !== exp_cnt) begin failures++; $display("[TB] FAIL flush_cnt got=%0d exp=%0d", cnt_o, exp_cnt); end
    endtask

    // Asynchronous reset mid-burst, then draining resumes from the FIFO head.
    task automatic test_reset_mid();
        int p0;
        p0 = pop_total;
        @(negedge clk); ready_i = 1'b1;
        for (int w = 0; w < 4; w++) push(16'h0300 + 16'(w));
        #1;
        checks++; if (fifo_pop_o !== 1'b1) begin failures++; $display("[TB] FAIL rmid_pop0 got=%0b exp=1", fifo_pop_o); end
        @(negedge clk); #1;
        checks++; if (dato_o !== 16'h0300 || fifo_pop_o !== 1'b1) begin failures++; $display("[TB] FAIL rmid_w0 got=%h/%0b exp=0300/1", dato_o, fifo_pop_o); end
        accept();
        @(negedge clk); #1;
        checks++; if (valid_o !== 1'b1 || dato_o !== 16'h0301) begin failures++; $display("[TB] FAIL rmid_w1 got=%0b/%h exp=1/0301", valid_o, dato_o); end
        #1; rst_n = 1'b0; exp_cnt = '0; #1;
        checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0 || cnt_o !== '0 || fifo_pop_o !== 1'b0) begin
            failures++; $display("[TB] FAIL rmid_async got=%0b/%0b/%0d/%0b exp=0/0/0/0", valid_o, busy_o, cnt_o, fifo_pop_o);
        end
        @(posedge clk);
        @(negedge clk);
        checks++; if (pop_total - p0 !== 2) begin failures++; $display("[TB] FAIL rmid_no_pop got=%0d exp=2", pop_total - p0); end
        rst_n = 1'b1; #1;
        checks++; if (fifo_pop_o !== 1'b1) begin failures++; $display("[TB] FAIL rmid_resume got=%0b exp=1", fifo_pop_o); end
        @(negedge clk); #1;
        checks++; if (valid_o !== 1'b1 || dato_o !== 16'h0302 || fifo_pop_o !== 1'b1) begin failures++; $display("[TB] FAIL rmid_w2 got=%0b/%h/%0b exp=1/0302/1", valid_o, dato_o, fifo_pop_o); end
        accept();
        @(negedge clk); #1;
        checks++; if (dato_o !== 16'h0303 || fifo_pop_o !== 1'b0) begin failures++; $display("[TB] FAIL rmid_w3 got=%h/%0b exp=0303/0", dato_o, fifo_pop_o); end
        accept();
        @(negedge clk); #1;
        checks++; if (valid_o !== 1'b0 || cnt_o !== exp_cnt) begin failures++; $display("[TB] FAIL rmid_end got=%0b/%0d exp=0/%0d", valid_o, cnt_o, exp_cnt); end
    endtask

    // Enable gating, en_i falling while loaded, and pndng toggling.
    task automatic test_enable();
        int p0;
        p0 = pop_total;
        @(negedge clk); en_i = 1'b0; push(16'h0400); push(16'h0401);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            checks++; if (fifo_pop_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("[TB] FAIL en_off%0d got=%0b/%0b exp=0/0", i, fifo_pop_o, busy_o); end
        end
        @(negedge clk); en_i = 1'b1; #1;
        checks++; if (fifo_pop_o !== 1'b1) begin failures++; $display("[TB] FAIL en_on_pop got=%0b exp=1", fifo_pop_o); end
        @(negedge clk); en_i = 1'b0; #1;
        checks++; if (valid_o !== 1'b1 || dato_o !== 16'h0400 || fifo_pop_o !== 1'b0) begin failures++; $display("[TB] FAIL en_fall got=%0b/%h/%0b exp=1/0400/0", valid_o, dato_o, fifo_pop_o); end
        accept();
        @(negedge clk); #1;
        checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("[TB] FAIL en_fall_idle got=%0b/%0b exp=0/0", valid_o, busy_o); end
        @(negedge clk); hide = 1'b1; en_i = 1'b1; #1;
        checks++; if (fifo_pop_o !== 1'b0) begin failures++; $display("[TB] FAIL pndng_low_pop got=%0b exp=0", fifo_pop_o); end
        @(negedge clk); hide = 1'b0; #1;
        checks++; if (fifo_pop_o !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("[TB] FAIL pndng_high_pop got=%0b/%0b exp=1/0", fifo_pop_o, busy_o); end
        @(negedge clk); #1;
        checks++; if (valid_o !== 1'b1 || dato_o !== 16'h0401 || fifo_pop_o !== 1'b0) begin failures++; $display("[TB] FAIL en_w1 got=%0b/%h/%0b exp=1/0401/0", valid_o, dato_o, fifo_pop_o); end
        accept();
        @(negedge clk); #1;
        checks++; if (valid_o !== 1'b0 || cnt_o !== exp_cnt) begin failures++; $display("[TB] FAIL en_end got=%0b/%0d exp=0/%0d", valid_o, cnt_o, exp_cnt); end
        checks++; if (pop_total - p0 !== 2) begin failures++; $display("[TB] FAIL en_pops got=%0d exp=2", pop_total - p0); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_burst();
        test_flush();
        test_reset_mid();
        test_enable();
        checks++; if (pop_err !== 0) begin failures++; $display("[TB] FAIL pop_while_empty got=%0d exp=0", pop_err); end
        checks++; if (rd_ptr !== wr_ptr) begin failures++; $display("[TB] FAIL fifo_drained got=%0d exp=%0d", rd_ptr, wr_ptr); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
